// File: rtl/cmd_initiator.sv
// cmd_initiator
//
// Host-side initiator for the 4-byte serial command protocol
// (READ = 1, WRITE = 2, DRAW = 3). One request is accepted at a time.
// The block sends the 4-byte header and any write payload to a UART
// transmitter, and collects READ response bytes from a UART receiver.
//
// Header bytes:
//   READ/WRITE : op, count, addr[15:8], addr[7:0]
//   DRAW       : {draw_lines, 4'h3}, {draw_x, draw_y}, addr[15:8], addr[7:0]
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start             request strobe, sampled only when idle
//   op[1:0]           1 READ, 2 WRITE, 3 DRAW (0 is ignored)
//   count[7:0]        bytes minus one for READ/WRITE (ignored for DRAW)
//   addr[15:0]        memory address / GPU source address
//   draw_lines/x/y    4-bit DRAW arguments
//   wr_data, wr_valid write payload stream in
//   wr_ready          payload accept, high only while waiting for a payload byte
//   rd_data, rd_valid READ response byte out, one-cycle valid
//   busy              request in progress
//   done              one-cycle completion pulse
//   error             one-cycle pulse with done on read-response timeout
//   is_transmitting   UART TX busy
//   transmit, tx_byte UART TX one-cycle send strobe and byte
//   received, rx_byte UART RX one-cycle strobe and byte
//
// Optional feature: define CMD_INIT_TIMEOUT_EN to enable a per-byte
// read-response timeout of TIMEOUT_CYCLES cycles. Without it, error is
// tied low and a READ waits for its bytes indefinitely.

module cmd_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [7:0]  count,
    input  logic [15:0] addr,
    input  logic [3:0]  draw_lines,
    input  logic [3:0]  draw_x,
    input  logic [3:0]  draw_y,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic        is_transmitting,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    input  logic        received,
    input  logic [7:0]  rx_byte
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HDR_SEND = 3'd1;
    localparam logic [2:0] S_HDR_GAP  = 3'd2;
    localparam logic [2:0] S_WR_DATA  = 3'd3;
    localparam logic [2:0] S_WR_GAP   = 3'd4;
    localparam logic [2:0] S_RX_DATA  = 3'd5;
    localparam logic [2:0] S_FINISH   = 3'd6;

    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_DRAW  = 2'd3;

    logic [2:0]  state;
    logic [1:0]  op_q;
    logic [7:0]  count_q;
    logic [15:0] addr_q;
    logic [3:0]  lines_q;
    logic [3:0]  x_q;
    logic [3:0]  y_q;
    logic [1:0]  hdr_idx;
    logic [7:0]  remaining;
    logic [7:0]  hdr_byte;

`ifdef CMD_INIT_TIMEOUT_EN
    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer;
    logic               error_q;

    assign error = error_q;
`else
    // No timeout hardware; the comparison folds to a constant 0.
    assign error = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    // Payload is accepted only while parked in WR_DATA with the UART free.
    assign wr_ready = (state == S_WR_DATA) && !is_transmitting;

    // Header byte selected by the current header index.
    always_comb begin
        hdr_byte = '0;
        case (hdr_idx)
            2'd0:    hdr_byte = (op_q == OP_DRAW) ? {lines_q, 4'h3} : {6'd0, op_q};
            2'd1:    hdr_byte = (op_q == OP_DRAW) ? {x_q, y_q} : count_q;
            2'd2:    hdr_byte = addr_q[15:8];
            default: hdr_byte = addr_q[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            lines_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            hdr_idx   <= '0;
            remaining <= '0;
            transmit  <= 1'b0;
            tx_byte   <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef CMD_INIT_TIMEOUT_EN
            timer     <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            // Strobes default low; each state raises them for one cycle.
            transmit <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
`ifdef CMD_INIT_TIMEOUT_EN
            error_q  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start && (op != 2'd0)) begin
                        op_q      <= op;
                        count_q   <= count;
                        addr_q    <= addr;
                        lines_q   <= draw_lines;
                        x_q       <= draw_x;
                        y_q       <= draw_y;
                        remaining <= count;
                        hdr_idx   <= '0;
                        busy      <= 1'b1;
                        state     <= S_HDR_SEND;
                    end
                end

                S_HDR_SEND: begin
                    if (!is_transmitting) begin
                        transmit <= 1'b1;
                        tx_byte  <= hdr_byte;
                        if (hdr_idx != 2'd3) begin
                            state <= S_HDR_GAP;
                        end else begin
                            case (op_q)
                                OP_READ: begin
                                    state <= S_RX_DATA;
`ifdef CMD_INIT_TIMEOUT_EN
                                    timer <= '0;
`endif
                                end
                                OP_WRITE: state <= S_WR_GAP;
                                default:  state <= S_FINISH;
                            endcase
                        end
                    end
                end

                // Gives the UART one cycle to raise is_transmitting.
                S_HDR_GAP: begin
                    hdr_idx <= hdr_idx + 2'd1;
                    state   <= S_HDR_SEND;
                end

                S_WR_GAP: begin
                    state <= S_WR_DATA;
                end

                S_WR_DATA: begin
                    if (wr_valid && wr_ready) begin
                        transmit <= 1'b1;
                        tx_byte  <= wr_data;
                        if (remaining == 8'd0) begin
                            state <= S_FINISH;
                        end else begin
                            remaining <= remaining - 8'd1;
                            state     <= S_WR_GAP;
                        end
                    end
                end

                S_RX_DATA: begin
                    if (received) begin
                        rd_data  <= rx_byte;
                        rd_valid <= 1'b1;
`ifdef CMD_INIT_TIMEOUT_EN
                        timer    <= '0;
`endif
                        if (remaining == 8'd0) begin
                            state <= S_FINISH;
                        end else begin
                            remaining <= remaining - 8'd1;
                        end
                    end
`ifdef CMD_INIT_TIMEOUT_EN
                    // Abort straight to IDLE; late bytes are dropped there.
                    else if (timer == TIMER_LAST) begin
                        done    <= 1'b1;
                        error_q <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end

                // busy drops together with the done pulse, so the block is
                // already idle and can take a new start in the done cycle.
                S_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
